// File: rtl/alu_seq_ctrl_pkg.sv
// ============================================================================
// Module : alu_seq_ctrl_pkg
// Brief  : ALU op codes, sequencer state encoding and the is_shift helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_seq_ctrl_pkg;

    localparam logic [3:0] FUNC_ZERO = 4'd0;
    localparam logic [3:0] FUNC_ADD  = 4'd1;
    localparam logic [3:0] FUNC_SUB  = 4'd2;
    localparam logic [3:0] FUNC_AND  = 4'd3;
    localparam logic [3:0] FUNC_OR   = 4'd4;
    localparam logic [3:0] FUNC_XOR  = 4'd5;
    localparam logic [3:0] FUNC_SLT  = 4'd6;
    localparam logic [3:0] FUNC_SLTU = 4'd7;
    localparam logic [3:0] FUNC_LLS  = 4'd8;
    localparam logic [3:0] FUNC_LRS  = 4'd9;
    localparam logic [3:0] FUNC_ARS  = 4'd10;
    localparam logic [3:0] FUNC_BEQ  = 4'd11;
    localparam logic [3:0] FUNC_BNE  = 4'd12;
    localparam logic [3:0] FUNC_BLT  = 4'd13;
    localparam logic [3:0] FUNC_BGE  = 4'd14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } seq_state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == FUNC_LLS) || (op == FUNC_LRS) || (op == FUNC_ARS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rr_arb2.sv
// ============================================================================
// Module : alu_rr_arb2
// Brief  : Two-way round-robin grant; the requester not served last wins a tie.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_rr_arb2 (
    input  logic [1:0] i_req_valid,
    input  logic       i_rr_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_req_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_rr_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
// ============================================================================
// Module : alu_seq_ctrl
// Brief  : Two-requester sequencer in front of a single-cycle ALU; multi-bit
//          shifts are built from repeated 1-bit ALU shifts.
//          Optional statistics counters: define ALU_SEQ_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_op0,
    input  logic [3:0]       req_op1,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b0,
    input  logic [31:0]      req_b1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    output logic             rsp_bcond,
    output logic [3:0]       alu_op,
    output logic [31:0]      alu_in_1,
    output logic [31:0]      alu_in_2,
    input  logic [31:0]      alu_result,
    input  logic             alu_bcond,
    output logic [CNT_W-1:0] stat_ops,
    output logic [CNT_W-1:0] stat_busy
);

    seq_state_e         r_state;
    seq_state_e         w_next_state;
    logic [3:0]         r_op;
    logic [31:0]        r_acc;
    logic [31:0]        r_b;
    logic               r_id;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_rr_last;
    logic [31:0]        r_rsp_result;
    logic               r_rsp_bcond;

    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_sel_id;
    logic [3:0]         w_sel_op;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic [SHAMT_W-1:0] w_sel_cnt;
    logic               w_rsp_hs;

    alu_rr_arb2 u_arb (
        .i_req_valid (req_valid),
        .i_rr_last   (r_rr_last),
        .o_grant     (w_grant)
    );

    // Ready is masked during reset so no requester sees a phantom handshake.
    assign req_ready = (r_state == IDLE && reset_n) ? w_grant : 2'b00;
    assign w_accept  = |req_ready;
    assign w_sel_id  = w_grant[1];
    assign w_sel_op  = w_sel_id ? req_op1 : req_op0;
    assign w_sel_a   = w_sel_id ? req_a1  : req_a0;
    assign w_sel_b   = w_sel_id ? req_b1  : req_b0;
    assign w_sel_cnt = w_sel_b[SHAMT_W-1:0];
    assign w_rsp_hs  = (r_state == RESP) && rsp_ready;

    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_id;
    assign rsp_result = r_rsp_result;
    assign rsp_bcond  = r_rsp_bcond;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        alu_op       = FUNC_ZERO;
        alu_in_1     = 32'd0;
        alu_in_2     = 32'd0;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_next_state = (is_shift(w_sel_op) && w_sel_cnt != '0) ? SHIFT : EXEC;
            end
            EXEC: begin
                // A zero-amount shift degenerates to a pass-through of operand A.
                if (is_shift(r_op)) begin
                    alu_op   = FUNC_ADD;
                    alu_in_1 = r_acc;
                end else begin
                    alu_op   = r_op;
                    alu_in_1 = r_acc;
                    alu_in_2 = r_b;
                end
                w_next_state = RESP;
            end
            SHIFT: begin
                alu_op   = r_op;
                alu_in_1 = r_acc;
                if (r_cnt == SHAMT_W'(1)) w_next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_op         <= FUNC_ZERO;
            r_acc        <= 32'd0;
            r_b          <= 32'd0;
            r_id         <= 1'b0;
            r_cnt        <= '0;
            r_rr_last    <= 1'b1;
            r_rsp_result <= 32'd0;
            r_rsp_bcond  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_sel_op;
                        r_acc <= w_sel_a;
                        r_b   <= w_sel_b;
                        r_id  <= w_sel_id;
                        r_cnt <= w_sel_cnt;
                    end
                end
                EXEC: begin
                    r_rsp_result <= alu_result;
                    r_rsp_bcond  <= alu_bcond;
                end
                SHIFT: begin
                    r_acc <= alu_result;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_rsp_result <= alu_result;
                        r_rsp_bcond  <= 1'b0;
                    end
                end
                RESP: begin
                    if (w_rsp_hs) r_rr_last <= r_id;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [CNT_W-1:0] r_stat_ops;
    logic [CNT_W-1:0] r_stat_busy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stat_ops  <= '0;
            r_stat_busy <= '0;
        end else begin
            if (w_rsp_hs && r_stat_ops != '1)             r_stat_ops  <= r_stat_ops + 1'b1;
            if (r_state != IDLE && r_stat_busy != '1)     r_stat_busy <= r_stat_busy + 1'b1;
        end
    end

    assign stat_ops  = r_stat_ops;
    assign stat_busy = r_stat_busy;
`else
    assign stat_ops  = '0;
    assign stat_busy = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ============================================================================
// Module : tb_alu_seq_ctrl
// Brief  : Self-checking bench for alu_seq_ctrl with an ALU model and a
//          whole-operation reference (full-amount shifts, latency, round robin).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_bcond;
    logic [31:0] rsp_result;
    logic [3:0]  alu_op;
    logic [31:0] alu_in_1, alu_in_2, alu_result;
    logic        alu_bcond;
    logic [15:0] stat_ops, stat_busy;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic tb_rr_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_ctrl #(.CNT_W(16), .SHAMT_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_bcond(rsp_bcond),
        .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .alu_result(alu_result), .alu_bcond(alu_bcond),
        .stat_ops(stat_ops), .stat_busy(stat_busy)
    );

    // Operation semantics; shifts take an explicit amount (1 for the ALU itself).
    function automatic logic [31:0] f_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int sh);
        case (op)
            FUNC_ADD:  return a + b;
            FUNC_SUB:  return a - b;
            FUNC_AND:  return a & b;
            FUNC_OR:   return a | b;
            FUNC_XOR:  return a ^ b;
            FUNC_SLT:  return {31'd0, $signed(a) < $signed(b)};
            FUNC_SLTU: return {31'd0, a < b};
            FUNC_LLS:  return a << sh;
            FUNC_LRS:  return a >> sh;
            FUNC_ARS:  return $signed(a) >>> sh;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic logic f_bc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            FUNC_BEQ: return a == b;
            FUNC_BNE: return a != b;
            FUNC_BLT: return $signed(a) <  $signed(b);
            FUNC_BGE: return $signed(a) >= $signed(b);
            default:  return 1'b0;
        endcase
    endfunction

    always_comb begin
        alu_result = f_res(alu_op, alu_in_1, alu_in_2, 1);
        alu_bcond  = f_bc(alu_op, alu_in_1, alu_in_2);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic scramble_inputs();
        req_op0 = 4'($urandom); req_op1 = 4'($urandom);
        req_a0 = $urandom; req_a1 = $urandom; req_b0 = $urandom; req_b1 = $urandom;
    endtask

    // One request from requester id, checked end to end, with an optional response stall.
    task automatic do_txn(input int id, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        logic        sh, eb, b0, rid;
        logic [31:0] er, r0;
        int          n, elat, ecnt, t0, scnt, w;
        sh   = (op == FUNC_LLS) || (op == FUNC_LRS) || (op == FUNC_ARS);
        n    = int'(b[4:0]);
        er   = sh ? f_res(op, a, b, n) : f_res(op, a, b, 0);
        eb   = sh ? 1'b0 : f_bc(op, a, b);
        elat = (sh && n != 0) ? n + 1 : 2;
        ecnt = (sh && n != 0) ? n : 0;

        @(negedge clk);
        rsp_ready = 1'b0;
        if (id == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; req_valid = 2'b01; end
        else         begin req_op1 = op; req_a1 = a; req_b1 = b; req_valid = 2'b10; end
        #1;
        w = 0;
        while (req_ready == 2'b00 && w < 20) begin @(negedge clk); #1; w++; end
        if (req_ready == 2'b00) begin chk("accept_timeout", 0, 1); req_valid = 2'b00; return; end
        chk("grant_onehot", {30'd0, req_ready}, {30'd0, req_valid});
        t0 = cyc;

        @(negedge clk);
        req_valid = 2'b00;
        scramble_inputs();
        #1;
        scnt = 0; w = 0;
        while (!rsp_valid && w < 40) begin
            if (sh && alu_op == op) scnt++;
            @(negedge clk); #1; w++;
        end
        if (!rsp_valid) begin chk("rsp_timeout", 0, 1); return; end
        chk("latency", 32'(cyc - t0), 32'(elat));
        chk("result", rsp_result, er);
        chk("rsp_id", {31'd0, rsp_id}, 32'(id));
        chk("bcond", {31'd0, rsp_bcond}, {31'd0, eb});
        if (sh) chk("shift_cycles", 32'(scnt), 32'(ecnt));

        r0 = rsp_result; b0 = rsp_bcond; rid = rsp_id;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            req_valid = 2'b11;
            #1;
            chk("stall_no_accept", {30'd0, req_ready}, 0);
            chk("stall_valid", {31'd0, rsp_valid}, 1);
            chk("stall_result", rsp_result, r0);
            chk("stall_meta", {30'd0, rsp_id, rsp_bcond}, {30'd0, rid, b0});
        end
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("rsp_drop", {31'd0, rsp_valid}, 0);
        tb_rr_last = id[0];
    endtask

    // Both requesters always valid with ADD: grants must alternate.
    task automatic arb_test(input int n_rsp);
        logic [1:0]  exp_g;
        logic [31:0] pend_exp;
        int          pend_id, got, guard, just_acc;
        got = 0; guard = 0; just_acc = -1; pend_id = -1; pend_exp = 32'd0;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_op0 = FUNC_ADD; req_op1 = FUNC_ADD;
        req_a0 = $urandom; req_b0 = $urandom; req_a1 = $urandom; req_b1 = $urandom;
        req_valid = 2'b11;
        while (got < n_rsp && guard < 200) begin
            #1;
            if (req_ready != 2'b00) begin
                exp_g = tb_rr_last ? 2'b01 : 2'b10;
                chk("arb_grant", {30'd0, req_ready}, {30'd0, exp_g});
                pend_id  = tb_rr_last ? 0 : 1;
                pend_exp = (pend_id == 0) ? req_a0 + req_b0 : req_a1 + req_b1;
                just_acc = pend_id;
            end
            if (rsp_valid) begin
                chk("arb_rsp_id", {31'd0, rsp_id}, 32'(pend_id));
                chk("arb_result", rsp_result, pend_exp);
                tb_rr_last = pend_id[0];
                got++;
            end
            @(negedge clk);
            guard++;
            if (just_acc == 0) begin req_a0 = $urandom; req_b0 = $urandom; end
            if (just_acc == 1) begin req_a1 = $urandom; req_b1 = $urandom; end
            just_acc = -1;
        end
        if (got < n_rsp) chk("arb_timeout", 32'(got), 32'(n_rsp));
        req_valid = 2'b00;
        // Let the final handshake complete before the next test.
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic seen;
        int   w;
        reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        req_op0 = 4'd0; req_op1 = 4'd0;
        req_a0 = 32'd0; req_a1 = 32'd0; req_b0 = 32'd0; req_b1 = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_req_ready", {30'd0, req_ready}, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_meta", {30'd0, rsp_id, rsp_bcond}, 0);
        chk("rst_alu", {alu_op, alu_in_1[27:0]}, 0);
        chk("rst_stats", {stat_ops, stat_busy}, 0);
        reset_n = 1'b1;
        tb_rr_last = 1'b1;

        do_txn(0, FUNC_ADD, 32'd5, 32'd7, 0);
        do_txn(1, FUNC_LLS, 32'd1, 32'd4, 0);
        do_txn(0, FUNC_ARS, 32'h8000_0000, 32'd31, 1);
        do_txn(1, FUNC_LRS, 32'h8000_0000, 32'd31, 0);
        do_txn(0, FUNC_BLT, 32'hFFFF_FFFF, 32'd0, 5);
        do_txn(1, FUNC_BGE, 32'hFFFF_FFFF, 32'd0, 0);
        do_txn(0, 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        arb_test(8);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] rb;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb[4:0] = 5'd0;
            do_txn(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, rb,
                   int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a 20-step shift: no response may ever appear.
        @(negedge clk);
        req_op0 = FUNC_LLS; req_a0 = $urandom; req_b0 = 32'd20; req_valid = 2'b01;
        #1;
        w = 0;
        while (req_ready == 2'b00 && w < 20) begin @(negedge clk); #1; w++; end
        chk("mid_accept", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (10) @(negedge clk);
        #1;
        chk("mid_in_shift", {28'd0, alu_op}, {28'd0, FUNC_LLS});
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 0);
        chk("mid_rst_idle", {28'd0, alu_op}, {28'd0, FUNC_ZERO});
        reset_n = 1'b1;
        tb_rr_last = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("mid_no_rsp", {31'd0, seen}, 0);
        rsp_ready = 1'b0;

        do_txn(0, FUNC_LLS, 32'h0000_1234, 32'd0, 0);
        do_txn(1, FUNC_ARS, 32'hF000_00F0, 32'd1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencer and arbiter in front of the single-cycle ALU. Two requesters share one ALU through valid/ready request and response channels. Single-cycle ops (add, sub, logic, compare) take one ALU cycle. Multi-bit shifts are built by issuing the ALU's 1-bit shift op (LLS/LRS/ARS) repeatedly, once per cycle, until the requested amount is reached.

Parameters:
CNT_W, 16, width of the optional statistics counters
SHAMT_W, 5, width of the shift amount taken from req_b[SHAMT_W-1:0]

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
req_valid  input  2  per-requester request valid (bit i = requester i)
req_ready  output  2  per-requester accept; at most one bit high per cycle
req_op0 / req_op1  input  4  FUNC_* op code, one per requester
req_a0 / req_a1  input  32  operand A, one per requester
req_b0 / req_b1  input  32  operand B; for shifts, the low SHAMT_W bits are the amount
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed
rsp_id  output  1  index of the requester this response belongs to
rsp_result  output  32  result
rsp_bcond  output  1  branch condition (BEQ/BNE/BLT/BGE)
alu_op  output  4  to ALU
alu_in_1  output  32  to ALU
alu_in_2  output  32  to ALU
alu_result  input  32  from ALU
alu_bcond  input  1  from ALU
stat_ops  output  CNT_W  completed-operation count (optional feature)
stat_busy  output  CNT_W  non-IDLE cycle count (optional feature)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: state=IDLE; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_bcond=0; req_ready=0; rr_last=1 (requester 0 wins first); stat counters=0.
- The ALU is combinational. In IDLE and RESP the block drives alu_op=FUNC_ZERO and alu_in_1=alu_in_2=0.
- State IDLE:
  - req_ready is high for the granted requester only.
  - Grant: if only one requester is valid, it wins. If both are valid, the one not equal to rr_last wins.
  - On accept, latch op, a, b, id, and cnt=b[SHAMT_W-1:0].
  - Next state: SHIFT if op is LLS/LRS/ARS and cnt!=0; otherwise EXEC.
- State EXEC (one cycle):
  - Drive the ALU with the latched op, a and b.
  - A shift with cnt==0 is instead driven as FUNC_ADD with alu_in_2=0, so the result is a.
  - Register rsp_result<=alu_result and rsp_bcond<=alu_bcond, then go to RESP.
- State SHIFT:
  - Drive alu_op=latched op and alu_in_1=acc (acc=a on entry); alu_in_2 is don't-care, driven 0.
  - Each cycle: acc<=alu_result and cnt<=cnt-1.
  - When cnt==1: register the final result, set rsp_bcond=0, go to RESP.
- State RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_bcond are stable.
  - When rsp_ready: go to IDLE, rr_last<=id, rsp_valid<=0.
  - No request is accepted while in RESP.
- Latency: accept at cycle T.
  - Non-shift op: rsp_valid at T+2.
  - Shift by N>=1: rsp_valid at T+N+1, so an amount of 31 gives rsp_valid at T+32.
  - Shift by 0: rsp_valid at T+2.
- Throughput: after a handshake in RESP, the next accept is at the earliest in the following cycle.
- Unlisted or unused op codes pass through EXEC; the result is whatever the ALU returns (0).
- A requester dropping req_valid before accept is legal and has no effect. Inputs are only sampled on accept.
- Reset in any state returns to IDLE in the next cycle. An in-flight operation is discarded with no response.

Optional Feature:
ALU_SEQ_STATS_EN
- Defined:
  - stat_ops increments on each rsp handshake.
  - stat_busy increments every cycle state!=IDLE.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared header, alongside the existing FUNC_* op-code definitions: state encoding (IDLE, EXEC, SHIFT, RESP) and an is_shift(op) helper.
- Natural sub-module: alu_rr_arb2 (2-way round-robin grant from req_valid and rr_last, one-hot output).

Test Plan:
1. Req0 sends ADD with a=5, b=7; rsp_ready=1 -> rsp_valid at T+2, rsp_result=12, rsp_id=0.
2. Req1 sends LLS with a=1, b=4 -> alu_op=LLS for exactly 4 cycles, rsp_result=16, rsp_valid at T+5.
3. ARS with a=0x80000000, b=31 -> rsp_result=0xFFFFFFFF at T+32. LRS with the same inputs -> rsp_result=1.
4. Both requesters valid continuously with ADD -> grants alternate 0,1,0,1. Each response rsp_id matches.
5. BLT with a=-1, b=0 -> rsp_bcond=1, rsp_result=0. Hold rsp_ready=0 for 5 cycles -> outputs stable, no new accept.
6. Assert reset_n=0 mid-SHIFT (cnt=10) -> next cycle IDLE, rsp_valid=0, no response. A following shift with b=0 and a=0x1234 -> rsp_result=0x1234 at T+2.
